// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// display-enable and line/frame markers, all aligned to the current (x,y).
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 11,
   parameter int FW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_en,
   output logic          h_sync,
   output logic          v_sync,
   output logic          in_display,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [FW-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
          (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_timing
         $error("vga_timing_gen: every timing parameter must be at least 1");
      end
      if (((longint'(1) << CW) < longint'(H_TOTAL)) ||
          ((longint'(1) << CW) < longint'(V_TOTAL))) begin : g_bad_cw
         $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   function automatic logic in_window(input logic [CW-1:0] pos,
                                      input logic [CW-1:0] lo,
                                      input logic [CW-1:0] hi);
      return (pos >= lo) && (pos < hi);
   endfunction

   logic          h_end;
   logic          v_end;
   logic [CW-1:0] x_nxt;
   logic [CW-1:0] y_nxt;

   always_comb begin
      h_end = (x == H_LAST);
      v_end = (y == V_LAST);
      x_nxt = h_end ? '0 : x + CW'(1);
      y_nxt = y;
      if (h_end) begin
         y_nxt = v_end ? '0 : y + CW'(1);
      end
   end

   // Outputs are decoded from the next position so they land on the same
   // edge as x/y; v_sync follows y_nxt and therefore only moves at x=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= '0;
         y           <= '0;
         frame_cnt   <= '0;
         in_display  <= 1'b1;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
         h_sync      <= ~HS_POL;
         v_sync      <= ~VS_POL;
      end else if (clk_en) begin
         x           <= x_nxt;
         y           <= y_nxt;
         if (h_end && v_end) begin
            frame_cnt <= frame_cnt + FW'(1);
         end
         in_display  <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         line_start  <= (x_nxt == '0);
         frame_start <= (x_nxt == '0) && (y_nxt == '0);
         h_sync      <= in_window(x_nxt, HS_START, HS_END) ? HS_POL : ~HS_POL;
         v_sync      <= in_window(y_nxt, VS_START, VS_END) ? VS_POL : ~VS_POL;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small active-low, small active-high,
// default 640x480) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   logic clk_en;

   logic       hs_lo, vs_lo, de_lo, ls_lo, fs_lo;
   logic [3:0] x_lo, y_lo;
   logic [2:0] fc_lo;
   logic       hs_hi, vs_hi, de_hi, ls_hi, fs_hi;
   logic [3:0] x_hi, y_hi;
   logic [2:0] fc_hi;
   logic        hs_df, vs_df, de_df, ls_df, fs_df;
   logic [10:0] x_df, y_df;
   logic [7:0]  fc_df;

   int    n_assert = 0;
   int    n_fail   = 0;
   longint pix     = 0;

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(3)) dut_lo (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .h_sync(hs_lo), .v_sync(vs_lo), .in_display(de_lo), .x(x_lo), .y(y_lo),
      .line_start(ls_lo), .frame_start(fs_lo), .frame_cnt(fc_lo));

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FW(3)) dut_hi (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .h_sync(hs_hi), .v_sync(vs_hi), .in_display(de_hi), .x(x_hi), .y(y_hi),
      .line_start(ls_hi), .frame_start(fs_hi), .frame_cnt(fc_hi));

   vga_timing_gen dut_df (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .h_sync(hs_df), .v_sync(vs_df), .in_display(de_df), .x(x_df), .y(y_df),
      .line_start(ls_df), .frame_start(fs_df), .frame_cnt(fc_df));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x; int y; int fc;
      bit hs; bit vs; bit de; bit ls; bit fs;
   } exp_t;

   // Position derived purely from the number of enabled pixels since reset.
   function automatic exp_t model(input longint p, input int sel);
      exp_t e;
      int ha, hf, hs, hb, va, vf, vs, vb, fw, ht, vt;
      bit pol;
      if (sel == 2) begin
         ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; fw = 8;
      end else begin
         ha = 4; hf = 1; hs = 2; hb = 1; va = 3; vf = 1; vs = 1; vb = 1; fw = 3;
      end
      pol  = (sel == 1);
      ht   = ha + hf + hs + hb;
      vt   = va + vf + vs + vb;
      e.x  = int'(p % ht);
      e.y  = int'((p / ht) % vt);
      e.fc = int'((p / (ht * vt)) % (longint'(1) << fw));
      e.de = (e.x < ha) && (e.y < va);
      e.hs = ((e.x >= ha + hf) && (e.x < ha + hf + hs)) ? pol : !pol;
      e.vs = ((e.y >= va + vf) && (e.y < va + vf + vs)) ? pol : !pol;
      e.ls = (e.x == 0);
      e.fs = (e.x == 0) && (e.y == 0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (pix=%0d)", tag, obs, exp, pix);
      end
   endtask

   task automatic check_dut(input string nm, input int sel,
                            input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] ofc,
                            input logic ohs, input logic ovs, input logic ode,
                            input logic ols, input logic ofs);
      exp_t e;
      e = model(pix, sel);
      chk({nm, ".x"}, ox, e.x);
      chk({nm, ".y"}, oy, e.y);
      chk({nm, ".frame_cnt"}, ofc, e.fc);
      chk({nm, ".h_sync"}, 32'(ohs), 32'(e.hs));
      chk({nm, ".v_sync"}, 32'(ovs), 32'(e.vs));
      chk({nm, ".in_display"}, 32'(ode), 32'(e.de));
      chk({nm, ".line_start"}, 32'(ols), 32'(e.ls));
      chk({nm, ".frame_start"}, 32'(ofs), 32'(e.fs));
   endtask

   task automatic check_all();
      check_dut("lo", 0, 32'(x_lo), 32'(y_lo), 32'(fc_lo), hs_lo, vs_lo, de_lo, ls_lo, fs_lo);
      check_dut("hi", 1, 32'(x_hi), 32'(y_hi), 32'(fc_hi), hs_hi, vs_hi, de_hi, ls_hi, fs_hi);
      check_dut("df", 2, 32'(x_df), 32'(y_df), 32'(fc_df), hs_df, vs_df, de_df, ls_df, fs_df);
   endtask

   task automatic tick();
      @(posedge clk);
      if (clk_en) pix++;
      #1;
      check_all();
   endtask

   // Called 1 time unit after a rising edge; reset is checked before the next edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1 pix = 0;
      check_all();
      chk("rst.x_lo", 32'(x_lo), 0);
      chk("rst.fs_lo", 32'(fs_lo), 1);
      #2 rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      clk_en = 1'b0;
      #2;
      pix = 0;
      check_all();
      #1 rst = 1'b0;

      // Continuous enable: two and a half small frames.
      clk_en = 1'b1;
      for (int i = 0; i < 120; i++) tick();

      // Half-rate enable: 192 clocks give exactly two frames.
      do_reset();
      for (int i = 0; i < 192; i++) begin
         clk_en = (i % 2 == 0);
         tick();
      end
      chk("half_rate.frame_cnt", 32'(fc_lo), 2);
      chk("half_rate.frame_start", 32'(fs_lo), 1);

      // Random enable pattern.
      for (int i = 0; i < 400; i++) begin
         clk_en = ($urandom_range(3) != 0);
         tick();
      end

      // Reset while counting at (3,2).
      clk_en = 1'b1;
      for (int i = 0; i < 60 && (pix % 48) != 19; i++) tick();
      chk("reach.x_lo", 32'(x_lo), 3);
      chk("reach.y_lo", 32'(y_lo), 2);
      do_reset();
      chk("rst_mid.frame_cnt", 32'(fc_lo), 0);

      // Eight full frames: last pixel, then wrap of frame_cnt to 0.
      for (int i = 0; i < 383; i++) tick();
      chk("wrap_pre.x", 32'(x_lo), 7);
      chk("wrap_pre.y", 32'(y_lo), 5);
      chk("wrap_pre.frame_cnt", 32'(fc_lo), 7);
      tick();
      chk("wrap.frame_cnt", 32'(fc_lo), 0);
      chk("wrap.frame_start", 32'(fs_lo), 1);
      chk("wrap.line_start", 32'(ls_lo), 1);

      // Default geometry: two complete 800-clock lines from a fresh reset.
      do_reset();
      for (int i = 0; i < 656; i++) tick();
      chk("df.hsync_start", 32'(hs_df), 0);
      chk("df.hsync_x", 32'(x_df), 656);
      for (int i = 0; i < 96; i++) tick();
      chk("df.hsync_end", 32'(hs_df), 1);
      for (int i = 0; i < 48; i++) tick();
      chk("df.line_period.x", 32'(x_df), 0);
      chk("df.line_period.y", 32'(y_df), 1);
      chk("df.line_start", 32'(ls_df), 1);
      for (int i = 0; i < 800; i++) tick();
      chk("df.line2.y", 32'(y_df), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, h_sync asserted level (0 = active-low)
- VS_POL, 0, v_sync asserted level (0 = active-low)
- CW, 11, width of the x and y coordinate outputs
- FW, 8, width of the frame counter

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock
- rst, in, 1: reset, asynchronous, active-high
- clk_en, in, 1: pixel advance enable
- h_sync, out, 1: horizontal sync
- v_sync, out, 1: vertical sync
- in_display, out, 1: current pixel is visible
- x, out, CW: horizontal position counter
- y, out, CW: vertical position counter
- line_start, out, 1: position is first pixel of a line
- frame_start, out, 1: position is first pixel of a frame
- frame_cnt, out, FW: completed-frame count

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 Elaboration SHALL fail ($error) if 2^CW < max(H_TOTAL, V_TOTAL) or if any timing parameter is less than 1.
REQ-005 x SHALL count 0..H_TOTAL-1 and SHALL advance by 1 on each clk rising edge with clk_en=1.
REQ-006 When x=H_TOTAL-1 and clk_en=1, x SHALL wrap to 0 and y SHALL advance by 1 on the same edge.
REQ-007 When x=H_TOTAL-1, y=V_TOTAL-1 and clk_en=1, both x and y SHALL wrap to 0 and frame_cnt SHALL increment on the same edge; frame_cnt SHALL wrap modulo 2^FW.
REQ-008 With clk_en=0, all state and all outputs SHALL hold their values unchanged.
REQ-009 All outputs SHALL be registered and updated on the same edge as x/y, so that each output reflects the new (x,y) position with zero added latency relative to x/y and no combinational path from clk_en.
REQ-010 in_display SHALL be 1 if and only if x<H_ACTIVE and y<V_ACTIVE.
REQ-011 h_sync SHALL equal HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, and !HS_POL otherwise.
REQ-012 v_sync SHALL equal VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, and !VS_POL otherwise; v_sync SHALL change only at x=0 transitions.
REQ-013 line_start SHALL be 1 if and only if x=0.
REQ-014 frame_start SHALL be 1 if and only if x=0 and y=0. Both line_start and frame_start SHALL therefore last exactly one clk_en-qualified pixel period.
REQ-015 The frame period SHALL be H_TOTAL*V_TOTAL clk_en-qualified edges, independent of the clk_en duty cycle.

Reset
REQ-016 rst=1 SHALL immediately, without waiting for a clk edge, force the following values, regardless of clk_en:
- x=0, y=0, frame_cnt=0
- in_display=1, line_start=1, frame_start=1
- h_sync=!HS_POL, v_sync=!VS_POL
REQ-017 Reset asserted mid-frame SHALL abandon the current frame without incrementing frame_cnt; counting SHALL resume from (0,0) on the first clk_en edge after rst deasserts.

Verification
Scenarios 1-5 use small parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), CW=4, FW=3.
REQ-018 Reset, then clk_en=1 continuously -> h_sync=0 exactly at x=5,6; v_sync=0 for all x of y=4; frame_start every 48 clk; in_display for 12 pixels per frame.
REQ-019 clk_en toggling 1,0,1,0 -> outputs hold on every clk_en=0 cycle; frame_start period becomes 96 clk; frame_cnt after 192 clk = 2.
REQ-020 Run to (7,5) and apply one clk_en edge -> (0,0), frame_start=1, line_start=1, frame_cnt increments; after 8 frames frame_cnt wraps to 0.
REQ-021 Pulse rst at (3,2) with clk_en=1 -> outputs take reset values before the next clk edge; frame_cnt=0; the first frame_start after release occurs 48 clk after counting resumes.
REQ-022 HS_POL=1, VS_POL=1 -> h_sync=1 only at x=5,6; v_sync=1 only at y=4; both idle at 0.
REQ-023 Default parameters with clk_en=1 -> line period 800 clk, h_sync low for 96 clk starting at x=656, v_sync low on y=490,491, frame period 420000 clk.
